// File: rtl/bcd_conv_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_conv_scheduler_pkg
// Description : Shared defaults, FSM encoding and digit-adjust helper for the
//               shared binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_conv_scheduler_pkg;

    localparam int c_num_req_dflt = 4;
    localparam int c_bin_w_dflt   = 16;
    localparam int c_num_dig_dflt = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Double-dabble correction: a digit of 5..9 would overflow after doubling.
    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        return (d > 4'd4) ? d + 4'd3 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_conv_scheduler_shift_core.sv
`default_nettype none
// ============================================================================
// Module      : bcd_conv_scheduler_shift_core
// Description : Iterative double-dabble datapath: load, BIN_W steps, last flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_conv_scheduler_shift_core
    import bcd_conv_scheduler_pkg::*;
#(
    parameter int BIN_W   = c_bin_w_dflt,
    parameter int NUM_DIG = c_num_dig_dflt
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [BIN_W-1:0]     i_data,
    input  logic                 i_step,
    output logic [4*NUM_DIG-1:0] o_bcd,
    output logic                 o_last_step
);

    localparam int c_cnt_w = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    logic [4*NUM_DIG-1:0]       r_bcd;
    logic [BIN_W-1:0]           r_bin;
    logic [c_cnt_w-1:0]         r_cnt;
    logic [4*NUM_DIG-1:0]       w_adj;
    logic [4*NUM_DIG+BIN_W-1:0] w_shift;

    for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
        assign w_adj[4*g +: 4] = dabble_adj(r_bcd[4*g +: 4]);
    end

    assign w_shift     = {w_adj, r_bin} << 1;
    assign o_bcd       = r_bcd;
    assign o_last_step = (r_cnt == c_cnt_w'(BIN_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd <= '0;
            r_bin <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_bcd <= '0;
            r_bin <= i_data;
            r_cnt <= '0;
        end else if (i_step) begin
            {r_bcd, r_bin} <= w_shift;
            r_cnt          <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bcd_conv_scheduler
// Description : Round-robin scheduler sharing one binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_conv_scheduler
    import bcd_conv_scheduler_pkg::*;
#(
    parameter int NUM_REQ = c_num_req_dflt,
    parameter int BIN_W   = c_bin_w_dflt,
    parameter int NUM_DIG = c_num_dig_dflt
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_REQ-1:0]                           req_valid,
    input  logic [NUM_REQ*BIN_W-1:0]                     req_data,
    output logic [NUM_REQ-1:0]                           req_ready,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [4*NUM_DIG-1:0]                         out_bcd,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] out_id,
    output logic                                         busy
);

    localparam int c_id_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_id_w-1:0]    r_rr_ptr;
    logic [c_id_w-1:0]    r_id;
    logic [4*NUM_DIG-1:0] r_last_bcd;
    logic [c_id_w-1:0]    w_grant_idx;
    logic                 w_grant_found;
    int                   w_idx;
    logic [BIN_W-1:0]     w_sel_data;
    logic                 w_load;
    logic                 w_step;
    logic [4*NUM_DIG-1:0] w_core_bcd;
    logic                 w_last_step;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_grant_found && req_valid[w_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = c_id_w'(w_idx);
            end
        end
    end

    assign w_sel_data = req_data[w_grant_idx*BIN_W +: BIN_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_found) begin
                    req_ready[w_grant_idx] = 1'b1;
                    w_load                 = 1'b1;
                    w_state_nxt            = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last_step) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The core register is reused by the next conversion, so keep a copy
    // of the delivered result for the idle/convert window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_last_bcd <= '0;
        end else begin
            if (w_load) begin
                r_id <= w_grant_idx;
            end
            if (r_state == ST_DONE && out_ready) begin
                r_last_bcd <= w_core_bcd;
                r_rr_ptr   <= (r_id == c_id_w'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
            end
        end
    end

    assign out_bcd = (r_state == ST_DONE) ? w_core_bcd : r_last_bcd;
    assign out_id  = r_id;

    bcd_conv_scheduler_shift_core #(
        .BIN_W   (BIN_W),
        .NUM_DIG (NUM_DIG)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_data      (w_sel_data),
        .i_step      (w_step),
        .o_bcd       (w_core_bcd),
        .o_last_step (w_last_step)
    );

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_conv_scheduler
// Description : Directed and random checks of the shared BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_conv_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_bcd;
    logic [1:0]  out_id;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state: free / counting down / result pending
    bit          m_free = 1'b1;
    bit          m_done = 1'b0;
    int          m_cnt  = 0;
    int          m_ptr  = 0;
    int          m_exp_id = 0;
    logic [19:0] m_exp_bcd  = '0;
    logic [19:0] m_last_bcd = '0;
    bit          m_after_rst = 1'b0;

    int          cyc = 0;
    int          g_last = -1;
    bit          obs_valid;
    logic [19:0] obs_bcd;
    logic [1:0]  obs_id;

    bcd_conv_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_id    (out_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input logic [15:0] v);
        int x;
        logic [19:0] r;
        x = int'(v);
        r = '0;
        for (int d = 0; d < 5; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // One clock: check outputs at negedge against the model, advance the model.
    task automatic tick();
        int g;
        logic [3:0] exp_rdy;
        @(negedge clk);
        cyc++;
        g_last    = -1;
        obs_valid = out_valid;
        obs_bcd   = out_bcd;
        obs_id    = out_id;
        if (rst) begin
            m_free = 1'b1; m_done = 1'b0; m_ptr = 0;
            m_last_bcd = '0; m_after_rst = 1'b1;
        end else begin
            g = -1;
            if (m_free) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                end
            end
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("busy", 32'(busy), 32'(!m_free));
            check("out_valid", 32'(out_valid), 32'(m_done));
            check("out_bcd", 32'(out_bcd), 32'(m_done ? m_exp_bcd : m_last_bcd));
            if (m_done) check("out_id", 32'(out_id), 32'(m_exp_id));
            if (m_after_rst) begin
                check("rst_out_id", 32'(out_id), 32'd0);
                m_after_rst = 1'b0;
            end
            if (g >= 0) begin
                m_free = 1'b0; m_cnt = 16; m_exp_id = g;
                m_exp_bcd = to_bcd(req_data[g*16 +: 16]);
                g_last = g;
            end else if (m_done) begin
                if (out_ready) begin
                    m_done = 1'b0; m_free = 1'b1;
                    m_last_bcd = m_exp_bcd;
                    m_ptr = (m_exp_id + 1) % 4;
                end
            end else if (!m_free) begin
                m_cnt--;
                if (m_cnt == 0) m_done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drain();
        req_valid = '0; out_ready = 1'b1;
        for (int n = 0; n < 40 && !m_free; n++) tick();
        if (!m_free) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_one(input int id, input logic [15:0] d, input logic [19:0] exp);
        int t0;
        bit seen;
        t0 = -1; seen = 1'b0;
        req_data[id*16 +: 16] = d; req_valid[id] = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 60 && !seen; n++) begin
            tick();
            if (g_last == id) begin req_valid[id] = 1'b0; t0 = cyc; end
            if (obs_valid) begin
                seen = 1'b1;
                check("latency", 32'(cyc - t0), 32'd17);
                check("result", 32'(obs_bcd), 32'(exp));
                check("result_id", 32'(obs_id), 32'(id));
            end
        end
        if (!seen) check("result_timeout", 32'd0, 32'd1);
        tick();
        check("valid_one_cycle", 32'(obs_valid), 32'd0);
    endtask

    initial begin
        int grants[5];
        int gcyc[5];
        int ng;
        bit seen;
        rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
        do_reset();

        // single conversions, including extremes
        run_one(2, 16'd1234, 20'h01234);
        run_one(0, 16'hFFFF, 20'h65535);
        run_one(3, 16'd0,    20'h00000);
        run_one(1, 16'd9999, 20'h09999);

        // backpressure on the result, then wrap of the pointer from 3 to 0
        req_data[48 +: 16] = 16'd4660; req_valid[3] = 1'b1; out_ready = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            tick();
            if (g_last == 3) req_valid[3] = 1'b0;
            seen = obs_valid;
        end
        if (!seen) check("bp_timeout", 32'd0, 32'd1);
        req_data[15:0] = 16'd7; req_valid[0] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            check("bp_valid", 32'(obs_valid), 32'd1);
            check("bp_bcd", 32'(obs_bcd), 32'h04660);
            check("bp_id", 32'(obs_id), 32'd3);
        end
        out_ready = 1'b1;
        tick();
        tick();
        check("wrap_grant", 32'(g_last), 32'd0);
        req_valid[0] = 1'b0;
        drain();

        // reset in the middle of a conversion
        req_data[16 +: 16] = 16'd555; req_valid[1] = 1'b1;
        tick();
        check("pre_rst_grant", 32'(g_last), 32'd1);
        req_valid[1] = 1'b0;
        for (int n = 0; n < 8; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_valid", 32'(obs_valid), 32'd0);
        check("post_rst_bcd", 32'(obs_bcd), 32'd0);
        run_one(1, 16'd4321, 20'h04321);

        // all requesters held high: strict rotation from pointer 0
        do_reset();
        req_data = {16'd3333, 16'd2222, 16'd1111, 16'd42};
        req_valid = 4'hF; out_ready = 1'b1;
        ng = 0;
        for (int n = 0; n < 120 && ng < 5; n++) begin
            tick();
            if (g_last >= 0) begin grants[ng] = g_last; gcyc[ng] = cyc; ng++; end
        end
        check("rr_count", 32'(ng), 32'd5);
        for (int i = 0; i < ng; i++) begin
            check("rr_order", 32'(grants[i]), 32'(i % 4));
            if (i > 0) check("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd18);
        end
        drain();

        // random requests and backpressure against the model
        for (int n = 0; n < 5000; n++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (g_last == i || !req_valid[i]) begin
                    req_valid[i] = ($urandom % 3 == 0);
                    case ($urandom % 8)
                        0:       req_data[i*16 +: 16] = 16'h0000;
                        1:       req_data[i*16 +: 16] = 16'hFFFF;
                        2:       req_data[i*16 +: 16] = 16'd9999;
                        default: req_data[i*16 +: 16] = 16'($urandom);
                    endcase
                end else if ($urandom % 20 == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            out_ready = ($urandom % 10 < 6);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
